// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid) that cuts the ready path without adding latency.
// Also counts backpressured cycles in a saturating counter.
module pipe_skid_reg #(
    parameter int                DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any transfer; an out_fire this cycle is simply dropped with the rest.
            state_d = S_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = S_FULL;
                    end else if (out_fire) begin
                        main_d  = BUBBLE;
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                        state_d = S_ONE;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        occupancy = 2'd0;
        case (state_q)
            S_EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
            S_ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            S_FULL: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                occupancy = 2'd0;
            end
        endcase
        // Only flush and rst reach in_ready combinationally; everything else is registered.
        in_ready = in_ready & ~flush & ~rst;
    end

    assign out_data  = out_valid ? main_q : BUBBLE;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus random traffic checked against a queue model.
module tb_pipe_skid_reg;

    localparam int            DW   = 16;
    localparam int            CW   = 4;
    localparam logic [DW-1:0] BUB  = 16'hDEAD;
    localparam int            SMAX = (2 ** CW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready;
    logic [1:0]     occupancy;
    logic [CW-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq[$];
    int            mstall = 0;

    always #5 clk = ~clk;

    pipe_skid_reg #(
        .DATA_W(DW),
        .BUBBLE(BUB),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model across the edge.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic ordy,
                         input logic fl, input logic r);
        logic ov_e;
        logic ir_e;
        rst = r; flush = fl; in_valid = v; in_data = d; out_ready = ordy;
        #1;
        ov_e = (mq.size() > 0);
        ir_e = (mq.size() < 2) && !fl && !r;
        chk("out_valid", 32'(out_valid), 32'(ov_e));
        chk("out_data",  32'(out_data),  32'(ov_e ? mq[0] : BUB));
        chk("in_ready",  32'(in_ready),  32'(ir_e));
        chk("occupancy", 32'(occupancy), 32'(mq.size()));
        chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
        @(posedge clk);
        if (r) begin
            mq.delete();
            mstall = 0;
        end else begin
            if (ov_e && !ordy && mstall < SMAX) mstall++;
            if (fl) begin
                mq.delete();
            end else begin
                if (ov_e && ordy) void'(mq.pop_front());
                if (v && ir_e) mq.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // reset state
        cycle(1'b1, 16'h1111, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

        // streaming 1..4
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_data", 32'(out_data), 32'(i));
        end
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("stream_stall", 32'(stall_cnt), 32'd0);
        chk("stream_drain", 32'(out_data), 32'(BUB));

        // backpressure A then B
        cycle(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        chk("bp_occ1", 32'(occupancy), 32'd1);
        cycle(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
        chk("bp_occ2", 32'(occupancy), 32'd2);
        cycle(1'b1, 16'h00CC, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00CC, 1'b0, 1'b0, 1'b0);
        chk("bp_hold", 32'(out_data), 32'h00AA);
        chk("bp_stall", 32'(stall_cnt), 32'd3);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("bp_b", 32'(out_data), 32'h00BB);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // flush while full with C offered
        cycle(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0C0C, 1'b0, 1'b1, 1'b0);
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_data", 32'(out_data), 32'(BUB));
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // saturation
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("sat", 32'(stall_cnt), 32'd15);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        chk("sat_flush", 32'(stall_cnt), 32'd15);
        cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // reset mid-operation
        cycle(1'b1, 16'h0707, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 16'h0808, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_data", 32'(out_data), 32'(BUB));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 16'h0909, 1'b1, 1'b0, 1'b0);
        chk("rst_z", 32'(out_data), 32'h0909);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), DW'($urandom),
                  1'($urandom_range(0, 99) < 65), 1'($urandom_range(0, 99) < 5), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
